fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/all_pkgs.sv | 22 ++
 rtl/if_id_reg.sv | 34 +++
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/all_pkgs.sv
// rtl/all_pkgs.sv - shared constants and types for the fetch datapath
package all_pkgs;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] ECALL_INSTR  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
    localparam logic [6:0]  OPC_SYSTEM   = 7'b111_0011;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // Only the two exact environment-trap encodings stop fetch; other SYSTEM words do not.
    function automatic logic is_halt_instr(input logic [31:0] instr);
        return (instr[6:0] == OPC_SYSTEM) &&
               ((instr == ECALL_INSTR) || (instr == EBREAK_INSTR));
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, bubble and hold
module if_id_reg
    import all_pkgs::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             bubble,
    input  logic [WIDTH-1:0] instr,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] if_id_instr,
    output logic [WIDTH-1:0] if_id_pc,
    output logic [WIDTH-1:0] if_id_pc_plus4,
    output logic             if_id_valid
);

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            if_id_instr    <= WIDTH'(NOP_INSTR);
            if_id_pc       <= '0;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
        end else if (load) begin
            if_id_instr    <= instr;
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, RUN/HALT control and IF/ID capture
module fetch_stage
    import all_pkgs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          WIDTH    = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             imem_valid,
    output logic [WIDTH-1:0] if_id_instr,
    output logic [WIDTH-1:0] if_id_pc,
    output logic [WIDTH-1:0] if_id_pc_plus4,
    output logic             if_id_valid,
    output logic             halted
);

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_plus4;
    logic             load, bubble;
    logic [1:0]       unused_redirect_lsbs;

    assign unused_redirect_lsbs = redirect_pc[1:0];
    assign pc_plus4  = pc_q + WIDTH'(4);
    assign imem_addr = pc_q;
    assign imem_req  = (state_q == RUN) && !stall;
    assign halted    = (state_q == HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= WIDTH'(RESET_PC);
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    // Redirect wins over stall so a resolved branch is never lost behind a hazard hold.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        load    = 1'b0;
        bubble  = 1'b0;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[WIDTH-1:2], 2'b00};
            state_d = RUN;
            bubble  = 1'b1;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (state_q == HALT) begin
            bubble = 1'b1;
        end else if (!imem_valid) begin
            bubble = 1'b1;
        end else begin
            load = 1'b1;
            pc_d = pc_plus4;
            if (is_halt_instr(32'(imem_rdata))) begin
                state_d = HALT;
            end
        end
    end

    if_id_reg #(
        .WIDTH (WIDTH)
    ) u_if_id_reg (
        .clk            (clk),
        .rst            (rst),
        .load           (load),
        .bubble         (bubble),
        .instr          (imem_rdata),
        .pc             (pc_q),
        .pc_plus4       (pc_plus4),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - vector table, wrap sequence and randomized model check for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid, imem_valid;
    logic [31:0] redirect_pc, imem_rdata, w_rdata;

    logic        imem_req, if_id_valid, halted;
    logic [31:0] imem_addr, if_id_instr, if_id_pc, if_id_pc_plus4;
    logic        w_req, w_valid, w_halted;
    logic [31:0] w_addr, w_instr, w_pc, w_pc4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .WIDTH(32)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
        .halted(halted)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .WIDTH(32)) dut_w (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .imem_valid(imem_valid),
        .if_id_instr(w_instr), .if_id_pc(w_pc),
        .if_id_pc_plus4(w_pc4), .if_id_valid(w_valid),
        .halted(w_halted)
    );

    typedef struct {
        logic        rst, stall, rv;
        logic [31:0] rpc;
        logic        iv;
        logic [31:0] rd;
        logic [31:0] e_addr;
        logic        e_req;
        logic        e_v;
        logic [31:0] e_instr, e_pc, e_pc4;
        logic        e_halt;
    } vec_t;

    function automatic vec_t mk(logic r, logic s, logic rv, logic [31:0] rpc, logic iv,
                                logic [31:0] rd, logic [31:0] ea, logic er, logic ev,
                                logic [31:0] ei, logic [31:0] ep, logic [31:0] ep4, logic eh);
        vec_t v;
        v.rst = r; v.stall = s; v.rv = rv; v.rpc = rpc; v.iv = iv; v.rd = rd;
        v.e_addr = ea; v.e_req = er; v.e_v = ev; v.e_instr = ei;
        v.e_pc = ep; v.e_pc4 = ep4; v.e_halt = eh;
        return v;
    endfunction

    function automatic logic [31:0] addi(int k);
        return 32'h0000_0093 | (32'(k) << 20);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic r, logic s, logic rv, logic [31:0] rpc, logic iv, logic [31:0] rd);
        @(negedge clk);
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
        imem_valid = iv; imem_rdata = rd; w_rdata = rd;
        #1;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] ECL = 32'h0000_0073;
    localparam logic [31:0] EBK = 32'h0010_0073;

    vec_t vt[22];

    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, rd, rpc;
    logic        m_halt, m_v, r, s, rv, iv;

    initial begin
        vt[0]  = mk(1,0,0,0,      1,addi(0), 32'h0,   1, 0,NOP,0,0,0);
        vt[1]  = mk(0,0,0,0,      1,addi(1), 32'h0,   1, 1,addi(1),32'h0,32'h4,0);
        vt[2]  = mk(0,0,0,0,      1,addi(2), 32'h4,   1, 1,addi(2),32'h4,32'h8,0);
        vt[3]  = mk(0,0,0,0,      1,addi(3), 32'h8,   1, 1,addi(3),32'h8,32'hC,0);
        vt[4]  = mk(0,1,0,0,      1,addi(4), 32'hC,   0, 1,addi(3),32'h8,32'hC,0);
        vt[5]  = mk(0,1,0,0,      1,addi(4), 32'hC,   0, 1,addi(3),32'h8,32'hC,0);
        vt[6]  = mk(0,0,0,0,      1,addi(4), 32'hC,   1, 1,addi(4),32'hC,32'h10,0);
        vt[7]  = mk(0,0,0,0,      0,addi(9), 32'h10,  1, 0,NOP,0,0,0);
        vt[8]  = mk(0,0,0,0,      1,addi(5), 32'h10,  1, 1,addi(5),32'h10,32'h14,0);
        vt[9]  = mk(0,1,1,32'h103,1,addi(6), 32'h14,  0, 0,NOP,0,0,0);
        vt[10] = mk(0,0,0,0,      1,addi(6), 32'h100, 1, 1,addi(6),32'h100,32'h104,0);
        vt[11] = mk(0,0,1,32'h20, 1,addi(7), 32'h104, 1, 0,NOP,0,0,0);
        vt[12] = mk(0,0,0,0,      1,ECL,     32'h20,  1, 1,ECL,32'h20,32'h24,1);
        vt[13] = mk(0,0,0,0,      1,addi(8), 32'h24,  0, 0,NOP,0,0,1);
        vt[14] = mk(0,0,0,0,      1,addi(8), 32'h24,  0, 0,NOP,0,0,1);
        vt[15] = mk(0,1,0,0,      1,addi(8), 32'h24,  0, 0,NOP,0,0,1);
        vt[16] = mk(0,0,1,32'h40, 1,addi(8), 32'h24,  0, 0,NOP,0,0,0);
        vt[17] = mk(0,0,0,0,      1,addi(9), 32'h40,  1, 1,addi(9),32'h40,32'h44,0);
        vt[18] = mk(0,0,0,0,      1,EBK,     32'h44,  1, 1,EBK,32'h44,32'h48,1);
        vt[19] = mk(1,1,1,32'h80, 1,addi(1), 32'h48,  0, 0,NOP,0,0,0);
        vt[20] = mk(0,0,0,0,      1,addi(1), 32'h0,   1, 1,addi(1),32'h0,32'h4,0);
        vt[21] = mk(0,0,1,32'h202,0,addi(2), 32'h4,   1, 0,NOP,0,0,0);

        drive(1, 0, 0, 0, 0, 0);
        post_edge();
        chk("reset_valid", 32'(if_id_valid), 0);
        chk("reset_instr", if_id_instr, NOP);
        chk("reset_halted", 32'(halted), 0);
        chk("reset_addr", imem_addr, 0);

        for (int i = 0; i < 22; i++) begin
            drive(vt[i].rst, vt[i].stall, vt[i].rv, vt[i].rpc, vt[i].iv, vt[i].rd);
            chk($sformatf("v%0d_addr", i), imem_addr, vt[i].e_addr);
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vt[i].e_req));
            post_edge();
            chk($sformatf("v%0d_valid", i), 32'(if_id_valid), 32'(vt[i].e_v));
            chk($sformatf("v%0d_instr", i), if_id_instr, vt[i].e_instr);
            chk($sformatf("v%0d_pc", i), if_id_pc, vt[i].e_pc);
            chk($sformatf("v%0d_pc4", i), if_id_pc_plus4, vt[i].e_pc4);
            chk($sformatf("v%0d_halted", i), 32'(halted), 32'(vt[i].e_halt));
        end

        drive(0, 0, 0, 0, 1, addi(3));
        chk("after_redirect_addr", imem_addr, 32'h200);

        // PC wrap through 2^32 from a reset vector at the top of the address space
        drive(1, 0, 0, 0, 1, addi(1));
        post_edge();
        drive(0, 0, 0, 0, 1, addi(1));
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        post_edge();
        chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", w_pc4, 32'h0);
        chk("wrap_valid", 32'(w_valid), 1);
        drive(0, 0, 0, 0, 1, addi(2));
        chk("wrap_addr1", w_addr, 32'h0);
        post_edge();
        chk("wrap_pc_second", w_pc, 32'h0);

        drive(1, 0, 0, 0, 0, 0);
        post_edge();
        m_pc = 0; m_halt = 0; m_v = 0; m_instr = NOP; m_ipc = 0; m_ipc4 = 0;
        for (int c = 0; c < 400; c++) begin
            r  = ($urandom_range(0, 31) == 0);
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 7) == 0);
            iv = ($urandom_range(0, 3) != 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            case ($urandom_range(0, 15))
                0, 1:    rd = ECL;
                2:       rd = EBK;
                default: rd = $urandom;
            endcase
            drive(r, s, rv, rpc, iv, rd);
            chk("rnd_addr", imem_addr, m_pc);
            chk("rnd_req", 32'(imem_req), 32'(!m_halt && !s));
            chk("rnd_halted", 32'(halted), 32'(m_halt));
            if (r) begin
                m_pc = 0; m_halt = 0;
                m_v = 0; m_instr = NOP; m_ipc = 0; m_ipc4 = 0;
            end else if (rv) begin
                m_pc = rpc & 32'hFFFF_FFFC; m_halt = 0;
                m_v = 0; m_instr = NOP; m_ipc = 0; m_ipc4 = 0;
            end else if (s) begin
                m_pc = m_pc;
            end else if (m_halt || !iv) begin
                m_v = 0; m_instr = NOP; m_ipc = 0; m_ipc4 = 0;
            end else begin
                m_v = 1; m_instr = rd; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
                m_halt = (rd == ECL) || (rd == EBK);
                m_pc = m_pc + 32'd4;
            end
            post_edge();
            chk("rnd_valid", 32'(if_id_valid), 32'(m_v));
            chk("rnd_instr", if_id_instr, m_instr);
            chk("rnd_pc", if_id_pc, m_ipc);
            chk("rnd_pc4", if_id_pc_plus4, m_ipc4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
